// File: rtl/bound_flash.sv
// bound_flash: 16-lamp bound flasher that moves one lamp per clock through bounds 0/5/10/15,
// with flick-triggered kickback at lamp 5 and lamp 10 during the rising phases.
module bound_flash (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flick,
  output logic [15:0] lamp
);
  typedef enum logic [2:0] {IDLE, UP_0_5, DN_5_0, UP_0_10, DN_10_5, UP_5_15, DN_15_0} state_t;
  state_t state, state_n;
  logic [15:0] lamp_n, up, dn;
  logic kick;
  assign up = {lamp[14:0], 1'b1};
  assign dn = {1'b0, lamp[15:1]};
  // kickback points are the lamp-5 and lamp-10 patterns
  assign kick = flick && (lamp == 16'h003F || lamp == 16'h07FF);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lamp  <= '0;
    end else begin
      state <= state_n;
      lamp  <= lamp_n;
    end
  always_comb begin
    state_n = state;
    lamp_n  = up;
    case (state)
      IDLE: begin
        state_n = flick ? UP_0_5 : IDLE;
        lamp_n  = flick ? 16'h0001 : 16'h0000;
      end
      UP_0_5: begin
        state_n = (lamp == 16'h003F) ? DN_5_0 : UP_0_5;
        lamp_n  = (lamp == 16'h003F) ? dn : up;
      end
      DN_5_0: begin
        state_n = (lamp == 16'h0000) ? UP_0_10 : DN_5_0;
        lamp_n  = (lamp == 16'h0000) ? up : dn;
      end
      UP_0_10: begin
        state_n = kick ? DN_5_0 : (lamp == 16'h07FF) ? DN_10_5 : UP_0_10;
        lamp_n  = (kick || lamp == 16'h07FF) ? dn : up;
      end
      DN_10_5: begin
        state_n = (lamp == 16'h001F) ? UP_5_15 : DN_10_5;
        lamp_n  = (lamp == 16'h001F) ? up : dn;
      end
      UP_5_15: begin
        state_n = kick ? DN_10_5 : (lamp == 16'hFFFF) ? DN_15_0 : UP_5_15;
        lamp_n  = (kick || lamp == 16'hFFFF) ? dn : up;
      end
      DN_15_0: begin
        state_n = (lamp == 16'h0000) ? IDLE : DN_15_0;
        lamp_n  = dn;
      end
      default: begin
        state_n = IDLE;
        lamp_n  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_bound_flash.sv
// tb_bound_flash: directed sequence checks of the bound flasher, lamp patterns held as ones-counts.
module tb_bound_flash;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flick = 1'b0;
  logic [15:0] lamp;
  int tests = 0;
  int fails = 0;
  int eq[$];
  bit fq[$];
  int u_base, c_base;

  bound_flash dut (.clk(clk), .rst_n(rst_n), .flick(flick), .lamp(lamp));

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input int k);
    logic [16:0] t;
    t = (17'd1 << k) - 17'd1;
    return t[15:0];
  endfunction

  task automatic seg(input int a, input int b);
    if (a <= b) for (int k = a; k <= b; k++) begin eq.push_back(k); fq.push_back(1'b0); end
    else for (int k = a; k >= b; k--) begin eq.push_back(k); fq.push_back(1'b0); end
  endtask

  // one full undisturbed pass from the starting edge back to IDLE, plus one idle edge
  task automatic normal();
    seg(1, 6); seg(5, 0); seg(1, 11); seg(10, 5);
    u_base = eq.size();
    seg(6, 16);
    c_base = eq.size();
    seg(15, 0); seg(0, 0); seg(0, 0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 tests++;
    if (lamp !== 16'h0000) begin fails++; $display("FAIL reset_async: lamp=%h expected 0000", lamp); end
    @(posedge clk); #1 tests++;
    if (lamp !== 16'h0000) begin fails++; $display("FAIL reset_hold: lamp=%h expected 0000", lamp); end
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    eq.delete(); fq.delete();
    normal(); fq[0] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL normal step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  task automatic test_kick_0_10_low();
    int k;
    eq.delete(); fq.delete();
    seg(1, 6); seg(5, 0); seg(1, 6);
    k = eq.size();
    seg(5, 0); seg(1, 11); seg(10, 5); seg(6, 16); seg(15, 0); seg(0, 0); seg(0, 0);
    fq[0] = 1'b1; fq[k] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL kick_0_10_at5 step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  task automatic test_kick_0_10_high();
    int k;
    eq.delete(); fq.delete();
    seg(1, 6); seg(5, 0); seg(1, 11);
    k = eq.size();
    seg(10, 0); seg(1, 11); seg(10, 5); seg(6, 16); seg(15, 0); seg(0, 0); seg(0, 0);
    fq[0] = 1'b1; fq[k] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL kick_0_10_at10 step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  task automatic test_kick_5_15_pulse();
    int k;
    eq.delete(); fq.delete();
    seg(1, 6); seg(5, 0); seg(1, 11); seg(10, 5); seg(6, 11);
    k = eq.size();
    seg(10, 5); seg(6, 16); seg(15, 0); seg(0, 0); seg(0, 0);
    fq[0] = 1'b1; fq[k] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL kick_5_15_pulse step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  task automatic test_kick_5_15_hold();
    eq.delete(); fq.delete();
    seg(1, 6); seg(5, 0); seg(1, 11); seg(10, 5); seg(6, 6);
    for (int j = 0; j < 4; j++) begin
      eq.push_back(5); fq.push_back(1'b1);
      eq.push_back(6); fq.push_back(1'b1);
    end
    seg(7, 16); seg(15, 0); seg(0, 0); seg(0, 0);
    fq[0] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL kick_5_15_hold step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  task automatic test_ignored_flicks();
    eq.delete(); fq.delete();
    normal();
    fq[0] = 1'b1;
    fq[1] = 1'b1;
    fq[3] = 1'b1;
    fq[u_base + 4] = 1'b1;
    fq[c_base + 14] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL ignored_flick step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  // flick on the IDLE re-entry edge is ignored, the next edge starts a new pass
  task automatic test_back_to_back();
    int k;
    eq.delete(); fq.delete();
    normal();
    fq[0] = 1'b1;
    fq[c_base + 16] = 1'b1;
    void'(eq.pop_back()); void'(fq.pop_back());
    k = eq.size();
    normal();
    fq[k] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL back_to_back step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  task automatic test_idle_reset();
    int k;
    for (int i = 0; i < 3; i++) begin
      flick = 1'b0; @(posedge clk); #1 tests++;
      if (lamp !== 16'h0000) begin fails++; $display("FAIL idle_hold step %0d: lamp=%h expected 0000", i, lamp); end
    end
    eq.delete(); fq.delete();
    normal();
    fq[0] = 1'b1; fq[1] = 1'b1; fq[2] = 1'b1;
    for (int i = 0; i < c_base + 8; i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL idle_flick_held step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
    #2 rst_n = 1'b0;
    #1 tests++;
    if (lamp !== 16'h0000) begin fails++; $display("FAIL reset_mid_dn: lamp=%h expected 0000", lamp); end
    @(posedge clk); #1 tests++;
    if (lamp !== 16'h0000) begin fails++; $display("FAIL reset_mid_hold: lamp=%h expected 0000", lamp); end
    rst_n = 1'b1;
    eq.delete(); fq.delete();
    seg(0, 0); seg(0, 0); seg(0, 0);
    k = eq.size();
    normal();
    fq[k] = 1'b1;
    for (int i = 0; i < eq.size(); i++) begin
      flick = fq[i]; @(posedge clk); #1 tests++;
      if (lamp !== mk(eq[i])) begin fails++; $display("FAIL after_reset step %0d: lamp=%h expected %h", i, lamp, mk(eq[i])); end
    end
    flick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_kick_0_10_low();
    test_kick_0_10_high();
    test_kick_5_15_pulse();
    test_kick_5_15_hold();
    test_ignored_flicks();
    test_back_to_back();
    test_idle_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
